// File: rtl/bcd_conv_arbiter_if.sv
//==============================================================================
// Module      : bcd_conv_arbiter_if
// Description : Start/done handshake bundle between the arbiter and the shared
//               binary-to-BCD converter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bcd_conv_arbiter_if;
    logic       conv_start_o;
    logic [6:0] conv_bin_o;
    logic       conv_done_i;
    logic [3:0] conv_tens_i;
    logic [3:0] conv_ones_i;

    modport master (
        output conv_start_o,
        output conv_bin_o,
        input  conv_done_i,
        input  conv_tens_i,
        input  conv_ones_i
    );

    modport slave (
        input  conv_start_o,
        input  conv_bin_o,
        output conv_done_i,
        output conv_tens_i,
        output conv_ones_i
    );
endinterface

`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
//==============================================================================
// Module      : bcd_conv_arbiter
// Description : Round-robin sharing of one multi-cycle binary-to-BCD converter
//               between NUM_REQ score channels, with per-channel digit registers.
//               Optional converter watchdog enabled by macro CONV_TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_conv_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_n_i,
    input  wire logic [NUM_REQ-1:0]     req_i,
    input  wire logic [7*NUM_REQ-1:0]   bin_i,
    output logic      [NUM_REQ-1:0]     ack_o,
    output logic      [4*NUM_REQ-1:0]   tens_o,
    output logic      [4*NUM_REQ-1:0]   ones_o,
    output logic                        busy_o,
    output logic                        timeout_o,
    bcd_conv_arbiter_if.master          conv
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
            $error("bcd_conv_arbiter: illegal parameter value");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_GW-1:0]        r_grant;
    logic [c_GW-1:0]        r_last_grant;
    logic [6:0]             r_conv_bin;
    logic                   r_conv_start;
    logic [NUM_REQ-1:0]     r_ack;
    logic [4*NUM_REQ-1:0]   r_tens;
    logic [4*NUM_REQ-1:0]   r_ones;

    logic [c_GW-1:0]        w_next_grant;
    logic [c_GW-1:0]        w_idx;
    logic                   w_any_req;
    logic [6:0]             w_sel_bin;
    logic [6:0]             w_sat_bin;

`ifdef CONV_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_CNT_W-1:0]     r_wait_cnt;
    logic                   r_timeout;
`endif

    // Walk offsets from the far end back to +1 so the nearest requester above
    // last_grant is the final (winning) assignment.
    always_comb begin
        w_any_req    = |req_i;
        w_next_grant = r_last_grant;
        w_idx        = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = c_GW'((int'(r_last_grant) + i) % NUM_REQ);
            if (req_i[w_idx]) begin
                w_next_grant = w_idx;
            end
        end
        w_sel_bin = bin_i[int'(w_next_grant)*7 +: 7];
        w_sat_bin = (w_sel_bin > 7'd99) ? 7'd99 : w_sel_bin;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= c_GW'(NUM_REQ - 1);
            r_conv_bin   <= '0;
            r_conv_start <= 1'b0;
            r_ack        <= '0;
            r_tens       <= '0;
            r_ones       <= '0;
`ifdef CONV_TIMEOUT_EN
            r_wait_cnt   <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_ack        <= '0;
            r_conv_start <= 1'b0;
`ifdef CONV_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant      <= w_next_grant;
                        r_conv_bin   <= w_sat_bin;
                        r_conv_start <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef CONV_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state    <= S_WAIT;
                end
                // Digits and ack are loaded on the way into WRITE so they are
                // visible during the WRITE cycle itself.
                S_WAIT: begin
                    if (conv.conv_done_i) begin
                        r_tens[int'(r_grant)*4 +: 4] <= conv.conv_tens_i;
                        r_ones[int'(r_grant)*4 +: 4] <= conv.conv_ones_i;
                        r_ack[r_grant]               <= 1'b1;
                        r_state                      <= S_WRITE;
                    end
`ifdef CONV_TIMEOUT_EN
                    else if (r_wait_cnt == c_CNT_W'(TIMEOUT_CYC - 1)) begin
                        r_tens[int'(r_grant)*4 +: 4] <= 4'hE;
                        r_ones[int'(r_grant)*4 +: 4] <= 4'hE;
                        r_ack[r_grant]               <= 1'b1;
                        r_timeout                    <= 1'b1;
                        r_state                      <= S_WRITE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                    end
`endif
                end
                S_WRITE: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack_o             = r_ack;
    assign tens_o            = r_tens;
    assign ones_o            = r_ones;
    assign busy_o            = (r_state != S_IDLE);
    assign conv.conv_start_o = r_conv_start;
    assign conv.conv_bin_o   = r_conv_bin;

`ifdef CONV_TIMEOUT_EN
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_arbiter.sv
//==============================================================================
// Module      : tb_bcd_conv_arbiter
// Description : Self-checking bench for bcd_conv_arbiter with a 15-cycle
//               converter model and an expected-result queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bcd_conv_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int CONV_LAT    = 15;
    localparam int NV          = 7;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req   = '0;
    logic [7*NUM_REQ-1:0] bin   = '0;
    logic [NUM_REQ-1:0]   ack;
    logic [4*NUM_REQ-1:0] tens;
    logic [4*NUM_REQ-1:0] ones;
    logic                 busy;
    logic                 timeout;

    bcd_conv_arbiter_if conv_if ();

    bcd_conv_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .bin_i     (bin),
        .ack_o     (ack),
        .tens_o    (tens),
        .ones_o    (ones),
        .busy_o    (busy),
        .timeout_o (timeout),
        .conv      (conv_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         chan;
        logic [6:0] bin;
        logic [6:0] exp_bin;
        logic [3:0] t;
        logic [3:0] o;
        bit         to;
    } job_t;

    job_t       sb_q[$];
    job_t       tbl[NV];
    job_t       mon_j;
    int         n_cmp     = 0;
    int         n_err     = 0;
    int         cyc       = 0;
    int         done_cyc  = -100;
    int         start_cyc = -100;
    int         ack_count = 0;
    logic [3:0] sh_t[NUM_REQ];
    logic [3:0] sh_o[NUM_REQ];
    bit         conv_en   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Converter model: answers CONV_LAT cycles after the start pulse.
    int         conv_cnt     = -1;
    logic [6:0] conv_lat_bin = '0;
    always @(posedge clk) begin
        conv_if.conv_done_i <= 1'b0;
        if (conv_if.conv_start_o === 1'b1) begin
            conv_cnt     <= CONV_LAT - 1;
            conv_lat_bin <= conv_if.conv_bin_o;
        end else if (conv_cnt > 0) begin
            conv_cnt <= conv_cnt - 1;
        end else if (conv_cnt == 0) begin
            conv_cnt <= -1;
            if (conv_en) begin
                conv_if.conv_done_i <= 1'b1;
                conv_if.conv_tens_i <= 4'(conv_lat_bin / 10);
                conv_if.conv_ones_i <= 4'(conv_lat_bin % 10);
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (conv_if.conv_done_i === 1'b1) done_cyc = cyc;
        if (conv_if.conv_start_o === 1'b1) begin
            start_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_start: got start with empty queue, required none");
            end else begin
                check("start_bin", 32'(conv_if.conv_bin_o), 32'(sb_q[0].exp_bin));
            end
        end
        if (rst_n === 1'b1 && ack !== '0) begin
            ack_count++;
            check("ack_onehot", 32'($countones(ack)), 32'd1);
            if (sb_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_ack: got ack=%b, required no ack", ack);
            end else begin
                mon_j = sb_q.pop_front();
                check("ack_chan", 32'(ack), 32'(1 << mon_j.chan));
                check("tens", 32'(tens[mon_j.chan*4 +: 4]), 32'(mon_j.t));
                check("ones", 32'(ones[mon_j.chan*4 +: 4]), 32'(mon_j.o));
                check("held_bin", 32'(conv_if.conv_bin_o), 32'(mon_j.exp_bin));
                check("timeout_flag", 32'(timeout), 32'(mon_j.to));
                if (!mon_j.to) check("ack_latency", 32'(cyc - done_cyc), 32'd1);
                else           check("timeout_latency", 32'(cyc - start_cyc), 32'(TIMEOUT_CYC + 1));
                sh_t[mon_j.chan] = mon_j.t;
                sh_o[mon_j.chan] = mon_j.o;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (k != mon_j.chan) begin
                        check("other_tens", 32'(tens[k*4 +: 4]), 32'(sh_t[k]));
                        check("other_ones", 32'(ones[k*4 +: 4]), 32'(sh_o[k]));
                    end
                end
            end
        end
    end

    task automatic wait_ack();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ack !== '0) return;
        end
        n_cmp++; n_err++;
        $display("FAIL wait_ack: no ack within 200 cycles, required one");
        sb_q.delete();
    endtask

    task automatic wait_start();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (conv_if.conv_start_o === 1'b1) return;
        end
        n_cmp++; n_err++;
        $display("FAIL wait_start: no start pulse within 20 cycles, required one");
    endtask

    task automatic run_job(input job_t j);
        bin[j.chan*7 +: 7] = j.bin;
        req[j.chan]        = 1'b1;
        sb_q.push_back(j);
        wait_ack();
        req[j.chan] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   acks;
        int   snap;
        job_t j;

        tbl[0] = '{0, 7'd42,  7'd42, 4'd4, 4'd2, 1'b0};
        tbl[1] = '{1, 7'd127, 7'd99, 4'd9, 4'd9, 1'b0};
        tbl[2] = '{0, 7'd0,   7'd0,  4'd0, 4'd0, 1'b0};
        tbl[3] = '{1, 7'd99,  7'd99, 4'd9, 4'd9, 1'b0};
        tbl[4] = '{0, 7'd100, 7'd99, 4'd9, 4'd9, 1'b0};
        tbl[5] = '{0, 7'd9,   7'd9,  4'd0, 4'd9, 1'b0};
        tbl[6] = '{1, 7'd10,  7'd10, 4'd1, 4'd0, 1'b0};
        for (int k = 0; k < NUM_REQ; k++) begin
            sh_t[k] = 4'd0;
            sh_o[k] = 4'd0;
        end

        repeat (3) @(negedge clk);
        check("rst_tens", 32'(tens), 32'd0);
        check("rst_ones", 32'(ones), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_start", 32'(conv_if.conv_start_o), 32'd0);
        check("rst_bin", 32'(conv_if.conv_bin_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NV; v++) run_job(tbl[v]);

        // Both channels held high: grants must alternate 0,1,0,1.
        bin[6:0]  = 7'd7;
        bin[13:7] = 7'd99;
        sb_q.push_back('{0, 7'd7,  7'd7,  4'd0, 4'd7, 1'b0});
        sb_q.push_back('{1, 7'd99, 7'd99, 4'd9, 4'd9, 1'b0});
        sb_q.push_back('{0, 7'd7,  7'd7,  4'd0, 4'd7, 1'b0});
        sb_q.push_back('{1, 7'd99, 7'd99, 4'd9, 4'd9, 1'b0});
        req  = 2'b11;
        acks = 0;
        for (int n = 0; n < 400 && acks < 4; n++) begin
            @(negedge clk);
            if (ack !== '0) acks++;
        end
        req = '0;
        check("rr_ack_count", 32'(acks), 32'd4);
        repeat (3) @(negedge clk);
        check("rr_queue_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Reset in the middle of WAIT abandons the job.
        bin[6:0] = 7'd33;
        req[0]   = 1'b1;
        sb_q.push_back('{0, 7'd33, 7'd33, 4'd3, 4'd3, 1'b0});
        wait_start();
        req[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_in_wait", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tens", 32'(tens), 32'd0);
        check("async_rst_ones", 32'(ones), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_bin", 32'(conv_if.conv_bin_o), 32'd0);
        check("async_rst_ack", 32'(ack), 32'd0);
        sb_q.delete();
        for (int k = 0; k < NUM_REQ; k++) begin
            sh_t[k] = 4'd0;
            sh_o[k] = 4'd0;
        end
        #1 rst_n = 1'b1;
        snap = ack_count;
        repeat (25) @(negedge clk);
        check("no_ack_after_reset", 32'(ack_count - snap), 32'd0);
        check("digits_after_reset", 32'({tens, ones}), 32'd0);
        check("idle_after_reset", 32'(busy), 32'd0);

        // Operand change after grant must not affect the latched value.
        bin[6:0] = 7'd10;
        req[0]   = 1'b1;
        sb_q.push_back('{0, 7'd10, 7'd10, 4'd1, 4'd0, 1'b0});
        wait_start();
        @(negedge clk);
        bin[6:0] = 7'd55;
        wait_ack();
        req[0] = 1'b0;
        repeat (3) @(negedge clk);

`ifdef CONV_TIMEOUT_EN
        conv_en   = 1'b0;
        bin[13:7] = 7'd50;
        req[1]    = 1'b1;
        sb_q.push_back('{1, 7'd50, 7'd50, 4'hE, 4'hE, 1'b1});
        wait_ack();
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        conv_en = 1'b1;
        check("idle_after_timeout", 32'(busy), 32'd0);
`endif

        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
